// File: rtl/cnt_cmp_param.sv
// Parametrised up/down counter with parallel load, optional saturation,
// programmable comparator and terminal-count flag. CNT_CMP_ZREG_EN registers Z.
module cnt_cmp_param #(
    parameter int WIDTH = 16,
    parameter int SAT   = 0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic             DIR,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic             at_top;
    logic             at_bot;
    logic             at_term;
    logic             cmp;
    logic [WIDTH-1:0] q_nxt;

    assign at_top  = (Q == ALL_ONES);
    assign at_bot  = (Q == '0);
    assign at_term = DIR ? at_bot : at_top;

    always_comb begin
        q_nxt = Q;
        if (LD) begin
            q_nxt = LD_VAL;
        end else if (EN) begin
            if ((SAT != 0) && at_term)
                q_nxt = Q;
            else if (DIR)
                q_nxt = Q - ONE;
            else
                q_nxt = Q + ONE;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            Q <= '0;
        else
            Q <= q_nxt;
    end

    // Mode 11 is equality restricted to an approaching count; a load breaks that.
    always_comb begin
        cmp = 1'b0;
        case (MODE)
            2'b00:   cmp = (Q == C);
            2'b01:   cmp = (Q >= C);
            2'b10:   cmp = (Q <  C);
            default: cmp = (Q == C) & ~LD;
        endcase
    end

    // Outputs are gated by RN so they read 0 throughout reset.
    assign TC = RN & EN & ~LD & at_term;

`ifdef CNT_CMP_ZREG_EN
    logic z_q;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            z_q <= 1'b0;
        else
            z_q <= EN & cmp;
    end

    assign Z = z_q;
`else
    assign Z = RN & EN & cmp;
`endif

endmodule

// File: tb/tb_cnt_cmp_param.sv
// Bench for cnt_cmp_param: wrap and saturating instances driven in parallel,
// checked against an integer reference model.
module tb_cnt_cmp_param;

    logic        CK = 1'b0;
    logic        rn, en, ld, dir;
    logic [15:0] ld_val, c;
    logic [1:0]  mode;
    logic [15:0] q_o  [2];
    logic        z_o  [2];
    logic        tc_o [2];

    int checks = 0;
    int errors = 0;

    logic [15:0] mq  [2];
    logic        mzr [2];
    int          sat_of [2] = '{0, 1};

    always #5 CK = ~CK;

    cnt_cmp_param #(.WIDTH(16), .SAT(0)) u_wrap (
        .CK(CK), .RN(rn), .EN(en), .LD(ld), .LD_VAL(ld_val), .DIR(dir),
        .C(c), .MODE(mode), .Q(q_o[0]), .Z(z_o[0]), .TC(tc_o[0])
    );

    cnt_cmp_param #(.WIDTH(16), .SAT(1)) u_sat (
        .CK(CK), .RN(rn), .EN(en), .LD(ld), .LD_VAL(ld_val), .DIR(dir),
        .C(c), .MODE(mode), .Q(q_o[1]), .Z(z_o[1]), .TC(tc_o[1])
    );

    function automatic logic m_cmp(logic [15:0] q);
        int qi = int'(q);
        int ci = int'(c);
        case (mode)
            2'd0: return qi == ci;
            2'd1: return qi >= ci;
            2'd2: return qi <  ci;
            default: return (qi == ci) && !ld;
        endcase
    endfunction

    function automatic logic m_tc(int i);
        return rn && en && !ld && (dir ? (mq[i] == 16'h0000) : (mq[i] == 16'hFFFF));
    endfunction

    function automatic logic m_z(int i);
`ifdef CNT_CMP_ZREG_EN
        return mzr[i];
`else
        return rn && en && m_cmp(mq[i]);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i]  = '0;
            mzr[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CK);
        if (rn) begin
            for (int i = 0; i < 2; i++) begin
                int v = int'(mq[i]);
                logic zn = en && m_cmp(mq[i]);
                if (ld)
                    v = int'(ld_val);
                else if (en && !dir)
                    v = (sat_of[i] != 0 && v == 65535) ? v : (v + 1) % 65536;
                else if (en && dir)
                    v = (sat_of[i] != 0 && v == 0) ? v : (v + 65535) % 65536;
                mq[i]  = v[15:0];
                mzr[i] = zn;
            end
        end
        #1;
    endtask

    task automatic drive(logic l, logic [15:0] lv, logic e, logic d);
        ld = l; ld_val = lv; en = e; dir = d;
    endtask

    task automatic test_reset();
        rn = 1'b0; drive(0, 16'h0, 1, 1); c = 16'h0; mode = 2'd0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q_o[i] !== 16'h0 || z_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got q=%h z=%b tc=%b want 0/0/0", i, q_o[i], z_o[i], tc_o[i]);
            end
        end
        rn = 1'b1;
        drive(0, 16'h0, 1, 0);
        repeat (7) tick();
        #2;
        rn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q_o[i] !== 16'h0 || z_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async[%0d] got q=%h z=%b tc=%b want 0/0/0", i, q_o[i], z_o[i], tc_o[i]);
            end
        end
        #1;
        rn = 1'b1;
    endtask

    task automatic test_count();
        drive(0, 16'h0, 1, 0); c = 16'h1234; mode = 2'd0;
        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q_o[i] !== 16'd5 || tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL count5[%0d] got q=%h tc=%b want 0005/0", i, q_o[i], tc_o[i]);
            end
        end
    endtask

    task automatic test_wrap();
        drive(1, 16'hFFFF, 0, 0);
        tick();
        drive(0, 16'h0, 1, 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (tc_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_tc_pre[%0d] got %b want 1", i, tc_o[i]);
            end
        end
        tick();
        checks++;
        if (q_o[0] !== 16'h0000 || tc_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_q got q=%h tc=%b want 0000/0", q_o[0], tc_o[0]);
        end
        checks++;
        if (q_o[1] !== 16'hFFFF || tc_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold_top got q=%h tc=%b want ffff/1", q_o[1], tc_o[1]);
        end
    endtask

    task automatic test_down();
        logic [15:0] exp_seq [3] = '{16'h0001, 16'h0000, 16'hFFFF};
        drive(1, 16'h0002, 0, 1);
        tick();
        drive(0, 16'h0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (q_o[0] !== exp_seq[k]) begin
                errors++;
                $display("FAIL down_wrap_q step %0d got %h want %h", k, q_o[0], exp_seq[k]);
            end
            checks++;
            if (q_o[1] !== ((k == 2) ? 16'h0000 : exp_seq[k])) begin
                errors++;
                $display("FAIL down_sat_q step %0d got %h want %h", k, q_o[1], (k == 2) ? 16'h0000 : exp_seq[k]);
            end
            if (k == 1) begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (tc_o[i] !== 1'b1) begin
                        errors++;
                        $display("FAIL down_tc_at0[%0d] got %b want 1", i, tc_o[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_compare();
        logic       tbl_eq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       tbl_gt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp;
        drive(1, 16'h0010, 0, 0);
        tick();
        ld = 1'b0;
        for (int pass = 0; pass < 3; pass++) begin
            for (int m = 0; m < 4; m++) begin
                en   = (pass != 2);
                c    = (pass == 1) ? 16'h0011 : 16'h0010;
                mode = 2'(m);
                #1;
                for (int i = 0; i < 2; i++) begin
`ifdef CNT_CMP_ZREG_EN
                    exp = m_z(i);
`else
                    exp = (pass == 2) ? 1'b0 : (pass == 1) ? tbl_gt[m] : tbl_eq[m];
`endif
                    checks++;
                    if (z_o[i] !== exp) begin
                        errors++;
                        $display("FAIL cmp_p%0d_m%0d[%0d] got %b want %b", pass, m, i, z_o[i], exp);
                    end
                end
            end
        end
        en = 1'b0;
        mode = 2'd3; c = 16'h0010; ld = 1'b1; ld_val = 16'h0010;
        #1;
        checks++;
        if (z_o[0] !== m_z(0)) begin
            errors++;
            $display("FAIL cmp_mode3_ld got %b want %b", z_o[0], m_z(0));
        end
        tick();
        ld = 1'b0;
    endtask

    task automatic test_priority();
        drive(1, 16'hFFFF, 0, 0);
        tick();
        drive(1, 16'h1234, 1, 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (tc_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL prio_tc[%0d] got %b want 0", i, tc_o[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q_o[i] !== 16'h1234) begin
                errors++;
                $display("FAIL prio_q[%0d] got %h want 1234", i, q_o[i]);
            end
        end
        ld = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] picks [4] = '{16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF};
        for (int n = 0; n < 600; n++) begin
            ld = ($urandom_range(0, 11) == 0);
            ld_val = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : 16'($urandom);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            c = ($urandom_range(0, 1) == 0) ? mq[0] + 16'($urandom_range(0, 2)) - 16'd1 : 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (q_o[i] !== mq[i] || z_o[i] !== m_z(i) || tc_o[i] !== m_tc(i)) begin
                    errors++;
                    $display("FAIL rand n=%0d[%0d] got q=%h z=%b tc=%b want q=%h z=%b tc=%b",
                             n, i, q_o[i], z_o[i], tc_o[i], mq[i], m_z(i), m_tc(i));
                end
            end
            if (n % 150 == 75) begin
                rn = 1'b0;
                model_reset();
                #1;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (q_o[i] !== 16'h0 || z_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_reset n=%0d[%0d] got q=%h z=%b tc=%b want 0/0/0",
                                 n, i, q_o[i], z_o[i], tc_o[i]);
                    end
                end
                #1;
                rn = 1'b1;
            end
            tick();
        end
    endtask

`ifdef CNT_CMP_ZREG_EN
    task automatic test_zreg();
        drive(1, 16'h0000, 0, 0); c = 16'd3; mode = 2'd0;
        tick();
        drive(0, 16'h0, 1, 0);
        repeat (3) tick();
        checks++;
        if (q_o[0] !== 16'd3 || z_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL zreg_q3 got q=%h z=%b want 0003/0", q_o[0], z_o[0]);
        end
        tick();
        checks++;
        if (z_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL zreg_late got %b want 1", z_o[0]);
        end
        #2;
        rn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (z_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL zreg_reset got %b want 0", z_o[0]);
        end
        #1;
        rn = 1'b1;
    endtask
`endif

    initial begin
        rn = 1'b0; en = 1'b0; ld = 1'b0; dir = 1'b0;
        ld_val = '0; c = '0; mode = '0;
        model_reset();
        #2;
        test_reset();
        test_count();
        test_wrap();
        test_down();
        test_compare();
        test_priority();
        test_random();
`ifdef CNT_CMP_ZREG_EN
        test_zreg();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_cmp_param.md
# cnt_cmp_param

Parametrised synchronous counter with a programmable comparator. It is the successor to the fixed 16-bit, P_0-enabled counter/compare benchmark block. It adds configurable width, up/down counting, parallel load, optional saturation, a selectable compare mode and a terminal-count flag. It sits in the benchmark/timing-test suite as a scalable sequential datapath for STA-versus-PT correlation runs.

## Interface
Parameters:
- WIDTH, 16, counter and compare width; legal range 4..32.
- SAT, 0, 0 = wrap at the count boundary; 1 = hold at the boundary.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset; asynchronous, active-low.
- EN  input  1  count enable (P_0 equivalent); also qualifies Z and TC.
- LD  input  1  synchronous parallel load.
- LD_VAL  input  WIDTH  value loaded when LD=1.
- DIR  input  1  0 = count up, 1 = count down.
- C  input  WIDTH  compare operand.
- MODE  input  2  compare mode (see Operation).
- Q  output  WIDTH  counter state.
- Z  output  1  qualified compare result.
- TC  output  1  terminal-count flag.

## Operation
- Reset: RN=0 forces Q=0 immediately, independent of CK. With RN=0, Z=0 and TC=0. With CNT_CMP_ZREG_EN defined, the Z register also clears to 0.
- Update priority on each rising CK edge, RN=1:
  - LD=1: Q<=LD_VAL. EN and DIR are ignored.
  - Else EN=1, DIR=0: Q<=Q+1, modulo 2^WIDTH.
  - Else EN=1, DIR=1: Q<=Q-1, modulo 2^WIDTH.
  - Else Q holds.
- Saturation: with SAT=1, up-count at Q=2^WIDTH-1 holds, and down-count at Q=0 holds. With SAT=0 the counter wraps (all-ones→0 up, 0→all-ones down).
- Arithmetic: unsigned, WIDTH bits, no carry output. Carry propagates through the full width in one cycle, with no nibble pipelining.
- TC = EN & ~LD & (DIR ? Q==0 : Q==all-ones). TC is combinational and marks the cycle in which the next edge wraps (or, with SAT=1, saturates).
- Compare result cmp on unsigned values:
  - MODE=00: Q==C.
  - MODE=01: Q>=C.
  - MODE=10: Q<C.
  - MODE=11: Q==C, but only while counting toward C. Up: Q<=C is the reachable side; down: Q>=C. In effect the result is Q==C, but forced to 0 when LD=1.
- Z = EN & cmp. Z is 0 whenever EN=0.
- Changing MODE, C or DIR mid-count never disturbs Q. It affects Z/TC only, combinationally (or from the next edge in registered mode).

## Timing
- Q: registered; changes one CK edge after LD/EN is sampled.
- Z, TC default: combinational from Q, C, MODE, EN, LD, DIR, with zero-cycle latency.
- Reset assertion is asynchronous. Reset release takes effect at the first rising CK edge with RN=1. An edge coincident with deassertion must not count. Implementers add no synchronizer; the integrator guarantees the release timing.
- Reset asserted mid-count: Q=0 within the same cycle. Pending LD/EN are lost.
- Simultaneous LD and EN at the terminal value: the load wins, Q=LD_VAL, and TC=0 that cycle.

## Configuration
- CNT_CMP_ZREG_EN defined: Z is taken from a flop clocked by CK and reset by RN to 0. Z at edge n reflects EN & cmp sampled at edge n, giving one-cycle latency. TC stays combinational.
- Not defined: Z is purely combinational, as specified above. No extra flops are present.

## Test plan
- Reset and count: WIDTH=16, RN pulse low mid-cycle → Q=0 at once. Then EN=1, DIR=0 for 5 edges → Q=5, TC=0.
- Wrap: SAT=0, LD_VAL=0xFFFF, LD=1 for one edge, then EN=1 → TC=1 before the edge, Q=0x0000 after it. Repeat with SAT=1 → Q stays 0xFFFF while TC=1.
- Down count: load 2, DIR=1, EN=1 → Q=1 then 0 (TC=1), then 0xFFFF with SAT=0 or 0 with SAT=1.
- Compare modes: Q=0x0010, C=0x0010, EN=1 → Z=1 for MODE 00/01/11 and Z=0 for MODE 10. With C=0x0011: MODE 10 gives Z=1, and MODE 00/01 give Z=0. With EN=0 → Z=0 in every mode.
- Priority: LD=1, EN=1, Q=0xFFFF, DIR=0, LD_VAL=0x1234 → Q=0x1234 after the edge, TC=0.
- Registered Z (CNT_CMP_ZREG_EN, WIDTH=8): C=3, counting up from 0 → Z asserts on the edge after Q=3 is first presented, one cycle late relative to the combinational build. RN low → Z=0 immediately.
